// File: rtl/fast_window_gen_if.sv
// Pixel-in / window-out stream bundle for fast_window_gen.
// Coordinate signals exist only with FAST_WIN_COORD_EN.
interface fast_window_gen_if
`ifdef FAST_WIN_COORD_EN
  #(
    parameter int COL_BITS = 10,
    parameter int ROW_BITS = 9
  )
`endif
  ();
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_sof;
  logic        pix_ready;
  logic [23:0] filter_input_0;
  logic [23:0] filter_input_1;
  logic [23:0] filter_input_2;
  logic        win_valid;
  logic        win_ready;
`ifdef FAST_WIN_COORD_EN
  logic [COL_BITS-1:0] center_x;
  logic [ROW_BITS-1:0] center_y;
`endif

  modport slave (
    input  pix_in,
    input  pix_valid,
    input  pix_sof,
    input  win_ready,
    output pix_ready,
    output filter_input_0,
    output filter_input_1,
    output filter_input_2,
`ifdef FAST_WIN_COORD_EN
    output center_x,
    output center_y,
`endif
    output win_valid
  );

  modport master (
    output pix_in,
    output pix_valid,
    output pix_sof,
    output win_ready,
    input  pix_ready,
    input  filter_input_0,
    input  filter_input_1,
    input  filter_input_2,
`ifdef FAST_WIN_COORD_EN
    input  center_x,
    input  center_y,
`endif
    input  win_valid
  );
endinterface

// File: rtl/fast_window_gen.sv
// Streaming 3x3 window generator for the FAST keypoint filter.
// Optional centre coordinates with FAST_WIN_COORD_EN.
module fast_window_gen #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int COL_BITS = 10,
  parameter int ROW_BITS = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  fast_window_gen_if.slave bus
);
  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

  logic [COL_BITS-1:0] col_q, col_d, cur_c;
  logic [ROW_BITS-1:0] row_q, row_d, cur_r;
  logic [7:0]  lb1 [IMG_W];
  logic [7:0]  lb2 [IMG_W];
  logic [7:0]  lb1_rd, lb2_rd;
  logic [AW-1:0] idx;
  logic [23:0] t_q, t_d;
  logic [23:0] m_q, m_d;
  logic [23:0] b_q, b_d;
  logic [23:0] f0_q, f0_d;
  logic [23:0] f1_q, f1_d;
  logic [23:0] f2_q, f2_d;
  logic        wv_q, wv_d;
  logic        rdy, acc, hit;
`ifdef FAST_WIN_COORD_EN
  logic [COL_BITS-1:0] cx_q, cx_d;
  logic [ROW_BITS-1:0] cy_q, cy_d;
`endif

  assign rdy   = !wv_q || bus.win_ready;
  assign acc   = bus.pix_valid && rdy;
  // sof forces the accepted pixel to (0,0)
  assign cur_c = bus.pix_sof ? '0 : col_q;
  assign cur_r = bus.pix_sof ? '0 : row_q;
  assign idx   = AW'(cur_c);
  assign lb1_rd = lb1[idx];
  assign lb2_rd = lb2[idx];
  assign hit = acc
    && (cur_c >= COL_BITS'(2))
    && (cur_r >= ROW_BITS'(2));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    t_d   = t_q;
    m_d   = m_q;
    b_d   = b_q;
    f0_d  = f0_q;
    f1_d  = f1_q;
    f2_d  = f2_q;
    wv_d  = wv_q;
`ifdef FAST_WIN_COORD_EN
    cx_d  = cx_q;
    cy_d  = cy_q;
`endif
    if (acc) begin
      t_d = {lb2_rd, t_q[23:8]};
      m_d = {lb1_rd, m_q[23:8]};
      b_d = {bus.pix_in, b_q[23:8]};
      if (cur_c == COL_BITS'(IMG_W - 1)) begin
        col_d = '0;
        if (cur_r == ROW_BITS'(IMG_H - 1))
          row_d = '0;
        else
          row_d = cur_r + ROW_BITS'(1);
      end else begin
        col_d = cur_c + COL_BITS'(1);
        row_d = cur_r;
      end
    end
    if (rdy)
      wv_d = hit;
    if (hit) begin
      f0_d = t_d;
      f1_d = m_d;
      f2_d = b_d;
`ifdef FAST_WIN_COORD_EN
      cx_d = cur_c - COL_BITS'(1);
      cy_d = cur_r - ROW_BITS'(1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      t_q   <= '0;
      m_q   <= '0;
      b_q   <= '0;
      f0_q  <= '0;
      f1_q  <= '0;
      f2_q  <= '0;
      wv_q  <= 1'b0;
`ifdef FAST_WIN_COORD_EN
      cx_q  <= '0;
      cy_q  <= '0;
`endif
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      t_q   <= t_d;
      m_q   <= m_d;
      b_q   <= b_d;
      f0_q  <= f0_d;
      f1_q  <= f1_d;
      f2_q  <= f2_d;
      wv_q  <= wv_d;
`ifdef FAST_WIN_COORD_EN
      cx_q  <= cx_d;
      cy_q  <= cy_d;
`endif
    end
  end

  // line buffers stay unreset; row gating hides stale data
  always_ff @(posedge clk) begin
    if (acc) begin
      lb2[idx] <= lb1_rd;
      lb1[idx] <= bus.pix_in;
    end
  end

  assign bus.pix_ready      = rdy;
  assign bus.win_valid      = wv_q;
  assign bus.filter_input_0 = f0_q;
  assign bus.filter_input_1 = f1_q;
  assign bus.filter_input_2 = f2_q;
`ifdef FAST_WIN_COORD_EN
  assign bus.center_x = cx_q;
  assign bus.center_y = cy_q;
`endif
endmodule

// File: tb/tb_fast_window_gen.sv
// Bench for fast_window_gen on a 4x4 image.
// Reference keeps the frame in an array and queues expected windows.
module tb_fast_window_gen;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CB = 3;
  localparam int RB = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fast_window_gen_if
`ifdef FAST_WIN_COORD_EN
    #(.COL_BITS(CB), .ROW_BITS(RB))
`endif
    bus ();

  fast_window_gen #(
    .IMG_W(W), .IMG_H(H),
    .COL_BITS(CB), .ROW_BITS(RB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic [23:0]   f0;
    logic [23:0]   f1;
    logic [23:0]   f2;
    logic [CB-1:0] cx;
    logic [RB-1:0] cy;
  } win_t;

  win_t q[$];
  logic [7:0] img [H][W];
  int mc = 0;
  int mr = 0;
  int checks = 0;
  int failures = 0;
  int wins = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic monitor();
    win_t e;
    e = '0;
    chk("win_valid", 64'(bus.win_valid), 64'(q.size() != 0));
    chk("pix_ready", 64'(bus.pix_ready),
        64'(q.size() == 0 || bus.win_ready));
    if (q.size() != 0) begin
      chk("f0", 64'(bus.filter_input_0), 64'(q[0].f0));
      chk("f1", 64'(bus.filter_input_1), 64'(q[0].f1));
      chk("f2", 64'(bus.filter_input_2), 64'(q[0].f2));
`ifdef FAST_WIN_COORD_EN
      chk("cx", 64'(bus.center_x), 64'(q[0].cx));
      chk("cy", 64'(bus.center_y), 64'(q[0].cy));
`endif
    end
    if (!rst_n) begin
      q.delete();
      mc = 0;
      mr = 0;
      return;
    end
    if (bus.win_valid && bus.win_ready) begin
      wins++;
      if (q.size() != 0) void'(q.pop_front());
    end
    if (bus.pix_valid && bus.pix_ready) begin
      if (bus.pix_sof) begin
        mc = 0;
        mr = 0;
      end
      img[mr][mc] = bus.pix_in;
      if (mr >= 2 && mc >= 2) begin
        e.f0 = {img[mr-2][mc], img[mr-2][mc-1], img[mr-2][mc-2]};
        e.f1 = {img[mr-1][mc], img[mr-1][mc-1], img[mr-1][mc-2]};
        e.f2 = {img[mr][mc], img[mr][mc-1], img[mr][mc-2]};
        e.cx = CB'(mc - 1);
        e.cy = RB'(mr - 1);
        q.push_back(e);
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr++;
        if (mr == H) mr = 0;
      end
    end
  endtask

  task automatic drive(input logic v, input logic s,
                       input logic [7:0] p,
                       input logic wr, input logic rn);
    @(posedge clk);
    #1;
    bus.pix_valid = v;
    bus.pix_sof   = s;
    bus.pix_in    = p;
    bus.win_ready = wr;
    rst_n         = rn;
    @(negedge clk);
    monitor();
  endtask

  task automatic send_frame(input logic sof0, input logic bp);
    int w0;
    w0 = wins;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        drive(1'b1, sof0 && r == 0 && c == 0,
              8'(16 * r + c), 1'b1, 1'b1);
        if (bp && r == 2 && c == 2) begin
          repeat (5) begin
            drive(1'b1, 1'b0, 8'h23, 1'b0, 1'b1);
            chk("bp_ready", 64'(bus.pix_ready), 64'd0);
            chk("bp_valid", 64'(bus.win_valid), 64'd1);
            chk("bp_f0", 64'(bus.filter_input_0), 64'h020100);
            chk("bp_f1", 64'(bus.filter_input_1), 64'h121110);
            chk("bp_f2", 64'(bus.filter_input_2), 64'h222120);
          end
        end
      end
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("last_valid", 64'(bus.win_valid), 64'd1);
    chk("last_f0", 64'(bus.filter_input_0), 64'h131211);
    chk("last_f1", 64'(bus.filter_input_1), 64'h232221);
    chk("last_f2", 64'(bus.filter_input_2), 64'h333231);
`ifdef FAST_WIN_COORD_EN
    chk("last_cx", 64'(bus.center_x), 64'd2);
    chk("last_cy", 64'(bus.center_y), 64'd2);
`endif
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("frame_wins", 64'(wins - w0), 64'd4);
  endtask

  initial begin
    int w0;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_in    = 8'h00;
    bus.win_ready = 1'b1;

    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("rst_valid", 64'(bus.win_valid), 64'd0);
    chk("rst_ready", 64'(bus.pix_ready), 64'd1);
    chk("rst_f0", 64'(bus.filter_input_0), 64'd0);
    chk("rst_f1", 64'(bus.filter_input_1), 64'd0);
    chk("rst_f2", 64'(bus.filter_input_2), 64'd0);

    send_frame(1'b1, 1'b1);
    send_frame(1'b0, 1'b0);
    send_frame(1'b0, 1'b0);

    for (int k = 0; k < 9; k++)
      drive(1'b1, k == 0, 8'(16 * (k / W) + k % W), 1'b1, 1'b1);
    w0 = wins;
    drive(1'b1, 1'b1, 8'h80, 1'b1, 1'b1);
    for (int k = 1; k < 16; k++) begin
      drive(1'b1, 1'b0, 8'(8'h80 + k), 1'b1, 1'b1);
      if (k <= 10)
        chk("sof_nowin", 64'(bus.win_valid), 64'd0);
      else if (k == 11)
        chk("sof_first", 64'(bus.win_valid), 64'd1);
    end
    repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("sof_wins", 64'(wins - w0), 64'd4);

    for (int k = 0; k < 14; k++)
      drive(1'b1, k == 0, 8'(k), 1'b1, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("mid_rst_valid", 64'(bus.win_valid), 64'd0);
    chk("mid_rst_ready", 64'(bus.pix_ready), 64'd1);
    send_frame(1'b0, 1'b0);

    for (int i = 0; i < 600; i++)
      drive(1'($urandom_range(0, 1)),
            $urandom_range(0, 63) == 0,
            8'($urandom),
            1'($urandom_range(0, 1)),
            1'b1);
    repeat (4) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    chk("drain_q", 64'(q.size()), 64'd0);
    chk("drain_valid", 64'(bus.win_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
